// File: rtl/uart_pixel_loader_pkg.sv
// uart_pixel_loader_pkg: state encoding, byte-lane indices and default frame size
// shared by the image loader and the read/transmit sequencer.
package uart_pixel_loader_pkg;
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, FIN} state_t;
   localparam logic [1:0] LANE_R = 2'd0;
   localparam logic [1:0] LANE_G = 2'd1;
   localparam logic [1:0] LANE_B = 2'd2;
   localparam int DEFAULT_PIXEL_COUNT = 8192;
   function automatic int lane_lsb(input logic [1:0] lane);
      return lane == LANE_R ? 16 : lane == LANE_G ? 8 : 0;
   endfunction
endpackage

// File: rtl/uart_pixel_loader_pixel_packer.sv
// uart_pixel_loader_pixel_packer: packs popped bytes into a {R,G,B} pixel.
// With LOADER_CHECKSUM_EN a running XOR of every packed byte is also kept.
module uart_pixel_loader_pixel_packer
   import uart_pixel_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        pop,
   input  logic [7:0]  r_data,
   output logic [23:0] pixel,
   output logic        pixel_valid
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  csum
`endif
);
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] pixel_q, pixel_d;
   always_comb begin
      pixel_d = pixel_q;
      if (pop) pixel_d[lane_lsb(byte_cnt_q) +: 8] = r_data;
      byte_cnt_d = clear ? LANE_R : !pop ? byte_cnt_q : byte_cnt_q == LANE_B ? LANE_R : byte_cnt_q + 2'd1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt_q <= LANE_R;
         pixel_q    <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         pixel_q    <= pixel_d;
      end
   end
   assign pixel       = pixel_q;
   assign pixel_valid = pop && byte_cnt_q == LANE_B;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   always_comb csum_d = clear ? 8'h00 : pop ? csum_q ^ r_data : csum_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum_q <= 8'h00;
      else csum_q <= csum_d;
   end
   assign csum = csum_q;
`endif
endmodule

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: drains the UART RX FIFO, packs 3 bytes per RGB pixel and writes the image RAM.
// Define LOADER_CHECKSUM_EN to verify a trailing XOR checksum byte after the frame.
module uart_pixel_loader
   import uart_pixel_loader_pkg::*;
#(
   parameter int ADDR_BITS   = 13,
   parameter int PIXEL_COUNT = DEFAULT_PIXEL_COUNT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 rx_empty,
   input  logic [7:0]           r_data,
   output logic                 rd_uart,
   output logic                 we,
   output logic [ADDR_BITS-1:0] addr,
   output logic [23:0]          wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 csum_err
);
   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 we_q, we_d, busy_q, busy_d, done_q, done_d;
   logic                 pixel_valid, last;
   assign last = addr_q == ADDR_BITS'(PIXEL_COUNT - 1);
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_err_q, csum_err_d;
   assign rd_uart  = (state_q == RECV || state_q == CSUM) && !rx_empty;
   assign csum_err = csum_err_q;
`else
   assign rd_uart  = state_q == RECV && !rx_empty;
   assign csum_err = 1'b0;
`endif
   uart_pixel_loader_pixel_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear       (state_q == IDLE && start),
      .pop         (rd_uart && state_q == RECV),
      .r_data      (r_data),
      .pixel       (wdata),
      .pixel_valid (pixel_valid)
`ifdef LOADER_CHECKSUM_EN
      ,
      .csum        (csum)
`endif
   );
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_err_d = csum_err_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = RECV;
            addr_d  = '0;
            busy_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_err_d = 1'b0;
`endif
         end
         RECV: if (pixel_valid) begin
            state_d = WRITE;
            we_d    = 1'b1;
         end
         WRITE: if (last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
         end else begin
            state_d = RECV;
            addr_d  = addr_q + 1'b1;
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: if (rd_uart) begin
            state_d    = FIN;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            csum_err_d = r_data != csum;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum_err_q <= 1'b0;
      else csum_err_q <= csum_err_d;
   end
`endif
   assign addr = addr_q;
   assign we   = we_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb_uart_pixel_loader: randomized frames on a 2-pixel loader against a byte-stream model,
// plus one full 8192-pixel frame on a default-size loader.
module tb_uart_pixel_loader;
   localparam int N  = 2;
   localparam int NB = 8192;
`ifdef LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   int n_chk  = 0;
   int n_fail = 0;

   logic        s_start = 1'b0;
   logic        s_rx_empty, s_rd_uart, s_we, s_busy, s_done, s_csum_err;
   logic [7:0]  s_r_data;
   logic [12:0] s_addr;
   logic [23:0] s_wdata;
   logic [7:0]  stim [0:511];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign s_rx_empty = rd_ptr == wr_ptr;
   assign s_r_data   = stim[rd_ptr];
   always @(posedge clk) if (s_rd_uart) rd_ptr <= rd_ptr + 1;

   uart_pixel_loader #(.ADDR_BITS(13), .PIXEL_COUNT(N)) dut (
      .clk(clk), .reset(reset), .start(s_start), .rx_empty(s_rx_empty), .r_data(s_r_data),
      .rd_uart(s_rd_uart), .we(s_we), .addr(s_addr), .wdata(s_wdata), .busy(s_busy),
      .done(s_done), .csum_err(s_csum_err));

   logic        b_start = 1'b0;
   logic        b_rd_uart, b_we, b_busy, b_done, b_csum_err;
   logic [7:0]  b_r_data;
   logic [12:0] b_addr;
   logic [23:0] b_wdata;
   int          b_cnt = 0;
   assign b_r_data = b_cnt[7:0];
   always @(posedge clk) if (b_rd_uart) b_cnt <= b_cnt + 1;

   uart_pixel_loader #(.ADDR_BITS(13), .PIXEL_COUNT(NB)) dut_big (
      .clk(clk), .reset(reset), .start(b_start), .rx_empty(1'b0), .r_data(b_r_data),
      .rd_uart(b_rd_uart), .we(b_we), .addr(b_addr), .wdata(b_wdata), .busy(b_busy),
      .done(b_done), .csum_err(b_csum_err));

   int          cyc = 0, both_hi = 0, done_n = 0, busy_rise = 0, done_at = 0;
   logic        busy_d1 = 1'b0;
   logic [12:0] wa [$];
   logic [23:0] wd [$];
   int          b_k = 0, b_bad = 0, b_zero = 0, b_last = -1, b_done_n = 0;
   always @(negedge clk) begin
      cyc     <= cyc + 1;
      busy_d1 <= s_busy;
      if (s_we) begin
         wa.push_back(s_addr);
         wd.push_back(s_wdata);
      end
      if ((s_we && s_rd_uart) || (b_we && b_rd_uart)) both_hi <= both_hi + 1;
      if (s_busy && !busy_d1) busy_rise <= cyc;
      if (s_done) begin
         done_n  <= done_n + 1;
         done_at <= cyc;
      end
      // pixel k of the counting stream is bytes 3k, 3k+1, 3k+2 written at address k
      if (b_we) begin
         if (b_addr !== 13'(b_k) || b_wdata !== {8'(3*b_k), 8'(3*b_k+1), 8'(3*b_k+2)}) b_bad <= b_bad + 1;
         if (b_addr == 13'd0) b_zero <= b_zero + 1;
         b_last <= int'(b_addr);
         b_k    <= b_k + 1;
      end
      if (b_done) b_done_n <= b_done_n + 1;
   end

   task automatic push(input logic [7:0] b);
      stim[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic pulse_start();
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      bit ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         ok = s_done;
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s timeout: done=0 after %0d cycles, required done=1", tag, lim);
      end
   endtask

   task automatic push_frame(input bit bad, input int gap);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      for (int i = 0; i < 3*N; i++) begin
         b = 8'($urandom);
         push(b);
         x ^= b;
         repeat ($urandom_range(0, gap)) @(negedge clk);
      end
      if (CK == 1) push(bad ? ~x : x);
   endtask

   task automatic check_frame(input string tag, input int p0, input int w0, input bit bad);
      logic [23:0] exp;
      for (int i = 0; i < N; i++) begin
         exp = {stim[p0+3*i], stim[p0+3*i+1], stim[p0+3*i+2]};
         n_chk++;
         if (w0 + i >= wa.size()) begin
            n_fail++;
            $display("FAIL %s pixel %0d: no write seen, required addr=%0d data=%06h", tag, i, i, exp);
         end else if (wa[w0+i] !== 13'(i) || wd[w0+i] !== exp) begin
            n_fail++;
            $display("FAIL %s pixel %0d: addr=%0d data=%06h, required addr=%0d data=%06h",
                     tag, i, wa[w0+i], wd[w0+i], i, exp);
         end
      end
      n_chk++;
      if (wa.size() - w0 != N) begin
         n_fail++;
         $display("FAIL %s write count: got %0d, required %0d", tag, wa.size() - w0, N);
      end
      n_chk++;
      if (rd_ptr - p0 != 3*N + CK) begin
         n_fail++;
         $display("FAIL %s pop count: got %0d, required %0d", tag, rd_ptr - p0, 3*N + CK);
      end
      n_chk++;
      if (s_csum_err !== (CK == 1 && bad)) begin
         n_fail++;
         $display("FAIL %s csum_err: got %b, required %b", tag, s_csum_err, CK == 1 && bad);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({s_busy, s_done, s_we, s_rd_uart, s_csum_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset flags: busy/done/we/rd/err=%b, required 00000",
                  {s_busy, s_done, s_we, s_rd_uart, s_csum_err});
      end
      n_chk++;
      if (s_addr !== 13'd0 || s_wdata !== 24'd0) begin
         n_fail++;
         $display("FAIL reset regs: addr=%0d wdata=%06h, required 0 and 000000", s_addr, s_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int p0 = rd_ptr;
      int w0 = wa.size();
      int d0 = done_n;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
      if (CK == 1) push(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66);
      pulse_start();
      wait_done("basic", 100);
      n_chk++;
      if (s_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic busy at done: got %b, required 0", s_busy);
      end
      @(negedge clk);
      n_chk++;
      if (s_done !== 1'b0 || done_n - d0 != 1) begin
         n_fail++;
         $display("FAIL basic done width: done=%b pulses=%0d, required 0 and 1", s_done, done_n - d0);
      end
      n_chk++;
      if (done_at - busy_rise != 4*N + CK) begin
         n_fail++;
         $display("FAIL basic latency: got %0d, required %0d", done_at - busy_rise, 4*N + CK);
      end
      n_chk++;
      if (wa.size() < w0 + 2 || wd[w0] !== 24'h112233 || wd[w0+1] !== 24'h445566) begin
         n_fail++;
         $display("FAIL basic pixels: %0d writes, required 112233 then 445566", wa.size() - w0);
      end
      check_frame("basic", p0, w0, 1'b0);
   endtask

   task automatic test_stall();
      int p0 = rd_ptr;
      int w0 = wa.size();
      int r1, w1;
      logic [7:0] x;
      pulse_start();
      push(8'($urandom));
      push(8'($urandom));
      repeat (4) @(negedge clk);
      r1 = rd_ptr;
      w1 = wa.size();
      repeat (20) @(negedge clk);
      n_chk++;
      if (rd_ptr != r1 || wa.size() != w1 || s_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stall: pops=%0d writes=%0d busy=%b, required 0 0 1", rd_ptr - r1, wa.size() - w1, s_busy);
      end
      x = stim[p0] ^ stim[p0+1];
      for (int i = 2; i < 3*N; i++) begin
         stim[wr_ptr] = 8'($urandom);
         x ^= stim[wr_ptr];
         wr_ptr = wr_ptr + 1;
      end
      if (CK == 1) push(x);
      wait_done("stall", 100);
      @(negedge clk);
      check_frame("stall", p0, w0, 1'b0);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         int p0 = rd_ptr;
         int w0 = wa.size();
         pulse_start();
         push_frame(1'b0, 3);
         wait_done("random", 200);
         @(negedge clk);
         check_frame("random", p0, w0, 1'b0);
      end
   endtask

   task automatic test_start_while_busy();
      int p0 = rd_ptr;
      int w0 = wa.size();
      int d0 = done_n;
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      push_frame(1'b0, 1);
      wait_done("restart", 200);
      @(negedge clk);
      check_frame("restart", p0, w0, 1'b0);
      repeat (10) @(negedge clk);
      n_chk++;
      if (s_busy !== 1'b0 || done_n - d0 != 1 || wa.size() - w0 != N) begin
         n_fail++;
         $display("FAIL restart ignored: busy=%b dones=%0d writes=%0d, required 0 1 %0d",
                  s_busy, done_n - d0, wa.size() - w0, N);
      end
   endtask

   task automatic test_reset_mid_frame();
      int p0 = rd_ptr;
      int p1, w1;
      pulse_start();
      push(8'hA5);
      repeat (3) @(negedge clk);
      n_chk++;
      if (rd_ptr != p0 + 1 || s_wdata[23:16] !== 8'hA5) begin
         n_fail++;
         $display("FAIL midreset setup: pops=%0d wdata=%06h, required 1 and A5xxxx", rd_ptr - p0, s_wdata);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if ({s_busy, s_done, s_we, s_rd_uart, s_csum_err} !== 5'b0 || s_addr !== 13'd0 || s_wdata !== 24'd0) begin
         n_fail++;
         $display("FAIL midreset outputs: flags=%b addr=%0d wdata=%06h, required 0",
                  {s_busy, s_done, s_we, s_rd_uart, s_csum_err}, s_addr, s_wdata);
      end
      @(negedge clk) reset = 1'b0;
      p1 = rd_ptr;
      w1 = wa.size();
      pulse_start();
      push_frame(1'b0, 2);
      wait_done("midreset", 200);
      @(negedge clk);
      check_frame("midreset", p1, w1, 1'b0);
   endtask

   task automatic test_checksum();
      int p0 = rd_ptr;
      int w0 = wa.size();
      push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h10); push(8'h20);
      if (CK == 1) push(8'h3E);
      pulse_start();
      wait_done("csum_bad", 100);
      @(negedge clk);
      check_frame("csum_bad", p0, w0, 1'b1);
      repeat (5) @(negedge clk);
      n_chk++;
      if (s_csum_err !== (CK == 1)) begin
         n_fail++;
         $display("FAIL csum hold: got %b, required %b", s_csum_err, CK == 1);
      end
      p0 = rd_ptr;
      w0 = wa.size();
      pulse_start();
      n_chk++;
      if (s_csum_err !== 1'b0) begin
         n_fail++;
         $display("FAIL csum clear on start: got %b, required 0", s_csum_err);
      end
      push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h10); push(8'h20);
      if (CK == 1) push(8'h3F);
      wait_done("csum_good", 100);
      @(negedge clk);
      check_frame("csum_good", p0, w0, 1'b0);
   endtask

   task automatic test_big_frame();
      bit ok = 0;
      @(negedge clk) b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      for (int i = 0; i < 4*NB + 50 && !ok; i++) begin
         @(negedge clk);
         ok = b_done;
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL big timeout: done=0, required done=1");
      end
      @(negedge clk);
      n_chk++;
      if (b_done !== 1'b0 || b_done_n != 1 || b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL big done: done=%b pulses=%0d busy=%b, required 0 1 0", b_done, b_done_n, b_busy);
      end
      n_chk++;
      if (b_k != NB || b_last != NB - 1 || b_zero != 1) begin
         n_fail++;
         $display("FAIL big addresses: writes=%0d last=%0d addr0_writes=%0d, required %0d %0d 1",
                  b_k, b_last, b_zero, NB, NB - 1);
      end
      n_chk++;
      if (b_bad != 0) begin
         n_fail++;
         $display("FAIL big pixels: %0d wrong, required 0", b_bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random_frames();
      test_start_while_busy();
      test_reset_mid_frame();
      test_checksum();
      test_big_frame();
      n_chk++;
      if (both_hi != 0) begin
         n_fail++;
         $display("FAIL we_rd_overlap: %0d cycles, required 0", both_hi);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
